// File: rtl/cc_screen_mux_seq.sv
// cc_screen_mux_seq
//   N-channel, W-bit screen-source selector with a registered output. A source
//   switch blanks the output for BLANK_CYCLES cycles before the new source
//   appears, so the display register never shows a mixed frame.
//
// Ports
//   CC_SCRMUX_CLOCK_50          in   system clock, rising edge
//   CC_SCRMUX_RESET_InLow       in   asynchronous active-low reset
//   CC_SCRMUX_data_InBUS        in   flattened channels, ch i at [i*DATA_WIDTH +: DATA_WIDTH]
//   CC_SCRMUX_select_InBUS      in   requested channel index
//   CC_SCRMUX_selectValid_In    in   select-request strobe
//   CC_SCRMUX_data_OutBUS       out  registered selected data
//   CC_SCRMUX_activeSel_OutBUS  out  channel currently driving the output
//   CC_SCRMUX_busy_Out          out  high while a switch is blanking
//   CC_SCRMUX_selError_Out      out  one-cycle pulse on an out-of-range request
module cc_screen_mux_seq #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned SEL_WIDTH    = 2,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] BLANK_VALUE = '0
) (
  input  logic                         CC_SCRMUX_CLOCK_50,
  input  logic                         CC_SCRMUX_RESET_InLow,
  input  logic [NUM_CH*DATA_WIDTH-1:0] CC_SCRMUX_data_InBUS,
  input  logic [SEL_WIDTH-1:0]         CC_SCRMUX_select_InBUS,
  input  logic                         CC_SCRMUX_selectValid_In,
  output logic [DATA_WIDTH-1:0]        CC_SCRMUX_data_OutBUS,
  output logic [SEL_WIDTH-1:0]         CC_SCRMUX_activeSel_OutBUS,
  output logic                         CC_SCRMUX_busy_Out,
  output logic                         CC_SCRMUX_selError_Out
);

  // Counter must hold BLANK_CYCLES-1; keep at least one bit when blanking is disabled.
  localparam int unsigned CntWidth = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [CntWidth-1:0] CntLoad =
    (BLANK_CYCLES > 0) ? CntWidth'(BLANK_CYCLES - 1) : '0;
  localparam logic [SEL_WIDTH:0] NumChExt = (SEL_WIDTH + 1)'(NUM_CH);

  typedef enum logic {
    LOCKED = 1'b0,
    BLANK  = 1'b1
  } stateT;

  stateT                 state, stateNext;
  logic [SEL_WIDTH-1:0]  pending, pendingNext;
  logic [CntWidth-1:0]   counter, counterNext;
  logic [DATA_WIDTH-1:0] dataNext;
  logic [SEL_WIDTH-1:0]  activeSelNext;
  logic                  busyNext;
  logic                  selErrorNext;
  logic                  inRange;
  logic                  reqOk;

  // Channel lookup; only in-range indices are ever passed, the default is unreachable.
  function automatic logic [DATA_WIDTH-1:0] chanData(
    input logic [NUM_CH*DATA_WIDTH-1:0] bus,
    input logic [SEL_WIDTH-1:0]         idx
  );
    logic [DATA_WIDTH-1:0] r;
    r = BLANK_VALUE;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == SEL_WIDTH'(i)) r = bus[i*DATA_WIDTH +: DATA_WIDTH];
    end
    return r;
  endfunction

  // Request qualification.
  always_comb begin
    inRange = ({1'b0, CC_SCRMUX_select_InBUS} < NumChExt);
    reqOk   = CC_SCRMUX_selectValid_In && inRange;
  end

  // Next-state and next-output logic.
  always_comb begin
    stateNext     = state;
    pendingNext   = pending;
    counterNext   = counter;
    dataNext      = CC_SCRMUX_data_OutBUS;
    activeSelNext = CC_SCRMUX_activeSel_OutBUS;
    busyNext      = CC_SCRMUX_busy_Out;
    selErrorNext  = CC_SCRMUX_selectValid_In && !inRange;

    case (state)
      LOCKED: begin
        dataNext = chanData(CC_SCRMUX_data_InBUS, CC_SCRMUX_activeSel_OutBUS);
        busyNext = 1'b0;
        if (reqOk && (CC_SCRMUX_select_InBUS != CC_SCRMUX_activeSel_OutBUS)) begin
          if (BLANK_CYCLES == 0) begin
            activeSelNext = CC_SCRMUX_select_InBUS;
            dataNext      = chanData(CC_SCRMUX_data_InBUS, CC_SCRMUX_select_InBUS);
          end else begin
            pendingNext = CC_SCRMUX_select_InBUS;
            counterNext = CntLoad;
            dataNext    = BLANK_VALUE;
            busyNext    = 1'b1;
            stateNext   = BLANK;
          end
        end
      end

      BLANK: begin
        dataNext = BLANK_VALUE;
        busyNext = 1'b1;
        // Last request wins; the counter keeps running.
        if (reqOk) pendingNext = CC_SCRMUX_select_InBUS;
        if (counter != '0) begin
          counterNext = counter - CntWidth'(1);
        end else begin
          activeSelNext = pendingNext;
          dataNext      = chanData(CC_SCRMUX_data_InBUS, pendingNext);
          busyNext      = 1'b0;
          stateNext     = LOCKED;
        end
      end

      default: begin
        stateNext = LOCKED;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CC_SCRMUX_CLOCK_50 or negedge CC_SCRMUX_RESET_InLow) begin
    if (!CC_SCRMUX_RESET_InLow) begin
      state                      <= LOCKED;
      pending                    <= '0;
      counter                    <= '0;
      CC_SCRMUX_data_OutBUS      <= BLANK_VALUE;
      CC_SCRMUX_activeSel_OutBUS <= '0;
      CC_SCRMUX_busy_Out         <= 1'b0;
      CC_SCRMUX_selError_Out     <= 1'b0;
    end else begin
      state                      <= stateNext;
      pending                    <= pendingNext;
      counter                    <= counterNext;
      CC_SCRMUX_data_OutBUS      <= dataNext;
      CC_SCRMUX_activeSel_OutBUS <= activeSelNext;
      CC_SCRMUX_busy_Out         <= busyNext;
      CC_SCRMUX_selError_Out     <= selErrorNext;
    end
  end

endmodule
